// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR command front end: pin-level command
// encoding, burst FSM states, mode-register code limits and small decode helpers.
package ddr_pkg;

    // Command encoding follows the pin order {cs_n, ras_n, cas_n, we_n}.
    typedef enum logic [3:0] {
        CMD_LOAD_MODE  = 4'b0000,
        CMD_REFRESH    = 4'b0001,
        CMD_PRECHARGE  = 4'b0010,
        CMD_ACTIVE     = 4'b0011,
        CMD_WRITE      = 4'b0100,
        CMD_READ       = 4'b0101,
        CMD_BURST_TERM = 4'b0110,
        CMD_NOP        = 4'b0111,
        CMD_DESELECT   = 4'b1000
    } ddr_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD,
        ST_WR,
        ST_GAP
    } burst_fsm_e;

    // Legal mode-register codes: BL code 1..3 (BL2/4/8), CAS latency 2..3.
    localparam logic [2:0] BL_CODE_MIN = 3'd1;
    localparam logic [2:0] BL_CODE_MAX = 3'd3;
    localparam logic [2:0] CL_MIN      = 3'd2;
    localparam logic [2:0] CL_MAX      = 3'd3;

    // Address bit that selects "all banks" on PRECHARGE.
    localparam int A10_BIT = 10;

    // Map the four command pins to a command; chip deselect masks everything else.
    function automatic ddr_cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                            input logic cas_n, input logic we_n);
        ddr_cmd_e cmd;
        // NOTE: assign a default before any branch so no path leaves the result
        // unassigned; in combinational context that is what keeps latches out.
        cmd = CMD_DESELECT;
        if (!cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b000:  cmd = CMD_LOAD_MODE;
                3'b001:  cmd = CMD_REFRESH;
                3'b010:  cmd = CMD_PRECHARGE;
                3'b011:  cmd = CMD_ACTIVE;
                3'b100:  cmd = CMD_WRITE;
                3'b101:  cmd = CMD_READ;
                3'b110:  cmd = CMD_BURST_TERM;
                default: cmd = CMD_NOP;
            endcase
        end
        return cmd;
    endfunction

    // Number of beats for a BL code: 1 -> 2, 2 -> 4, 3 -> 8.
    function automatic logic [3:0] burst_beats(input logic [2:0] bl_code);
        return 4'd2 << (bl_code - 3'd1);
    endfunction

    // True when a LOAD MODE operand carries a supported BL code and CAS latency.
    function automatic logic mode_valid(input logic [2:0] bl_code, input logic [2:0] cl);
        return (bl_code >= BL_CODE_MIN) && (bl_code <= BL_CODE_MAX) &&
               (cl >= CL_MIN) && (cl <= CL_MAX);
    endfunction

endpackage

// File: rtl/ddr_bank_tracker.sv
// Per-bank open-row bookkeeping: latches the row on ACTIVE, clears the open flag
// on PRECHARGE (single bank or all), and flags ACTIVE to an already open bank.
module ddr_bank_tracker #(
    parameter int ROW_WIDTH = 14
) (
    input  logic                       clk2x,
    input  logic                       rst_n,
    input  logic                       act_req_i,
    input  logic                       pre_req_i,
    input  logic                       pre_all_i,
    input  logic [1:0]                 bank_i,
    input  logic [ROW_WIDTH-1:0]       row_i,
    output logic [3:0][ROW_WIDTH-1:0]  ra_o,
    output logic [3:0]                 row_active_o,
    output logic                       act_reject_o
);

    logic [3:0][ROW_WIDTH-1:0] ra_q;
    logic [3:0]                row_active_q;

    // ACTIVE is illegal only when the addressed bank already holds an open row.
    assign act_reject_o = act_req_i && row_active_q[bank_i];

    // Open a row on a legal ACTIVE, close one or all banks on PRECHARGE.
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the row table is only four entries and is observable at the
            // pins, so it is reset like ordinary control state rather than left
            // uninitialised as a RAM would be.
            ra_q         <= '0;
            row_active_q <= '0;
        end else if (act_req_i && !row_active_q[bank_i]) begin
            // NOTE: non-blocking assignments for every clocked register so all
            // flops update from the same pre-edge values regardless of order.
            ra_q[bank_i]         <= row_i;
            row_active_q[bank_i] <= 1'b1;
        end else if (pre_req_i) begin
            if (pre_all_i) begin
                row_active_q <= '0;
            end else begin
                row_active_q[bank_i] <= 1'b0;
            end
        end
    end

    assign ra_o         = ra_q;
    assign row_active_o = row_active_q;

endmodule

// File: rtl/ddr_cmd_decoder.sv
// DDR1 command front end: decodes the command pins, holds the mode register,
// gates commands on bank/refresh/burst state, and times read/write beat windows
// for the bank array. Every output comes straight from flops.
module ddr_cmd_decoder
    import ddr_pkg::*;
#(
    parameter int ROW_WIDTH  = 14,
    parameter int COL_WIDTH  = 10,
    parameter int TRFC       = 8,
    parameter int DEFAULT_CL = 2
) (
    input  logic                       clk2x,
    input  logic                       rst_n,
    input  logic                       cs_n,
    input  logic                       ras_n,
    input  logic                       cas_n,
    input  logic                       we_n,
    input  logic [1:0]                 ba_in,
    input  logic [ROW_WIDTH-1:0]       addr,
    output logic [3:0][ROW_WIDTH-1:0]  ra,
    output logic [3:0]                 row_active,
    output logic [COL_WIDTH-1:0]       ca,
    output logic [1:0]                 ba,
    output logic [2:0]                 burst_len,
    output logic                       burst_type,
    output logic [2:0]                 cas_lat,
    output logic                       read_active,
    output logic                       write_active,
    output logic                       burst_stop,
    output logic                       cmd_err,
    output logic                       busy
);

    localparam int RCW = $clog2(TRFC + 1);

    ddr_cmd_e             cmd;
    burst_fsm_e           state_q;
    logic [3:0]           beat_cnt_q;
    logic [RCW-1:0]       ref_cnt_q;
    logic [COL_WIDTH-1:0] ca_q;
    logic [1:0]           ba_q;
    logic [2:0]           burst_len_q;
    logic                 burst_type_q;
    logic [2:0]           cas_lat_q;
    logic                 read_active_q;
    logic                 write_active_q;
    logic                 burst_stop_q;
    logic                 cmd_err_q;

    logic refreshing;
    logic cmd_window_open;
    logic bursting;
    logic rdwr_req;
    logic rdwr_accept;
    logic lmr_accept;
    logic ref_accept;
    logic pre_req;
    logic stop_burst;
    logic act_reject;
    logic cmd_err_d;

    ddr_bank_tracker #(
        .ROW_WIDTH (ROW_WIDTH)
    ) u_bank_tracker (
        .clk2x        (clk2x),
        .rst_n        (rst_n),
        .act_req_i    (cmd == CMD_ACTIVE),
        .pre_req_i    (pre_req),
        .pre_all_i    (addr[A10_BIT]),
        .bank_i       (ba_in),
        .row_i        (addr),
        .ra_o         (ra),
        .row_active_o (row_active),
        .act_reject_o (act_reject)
    );

    // Command legality: READ/WRITE/LOAD MODE/REFRESH need an idle FSM and no
    // refresh in flight; BURST TERMINATE or a PRECHARGE hitting the burst bank
    // aborts a running burst.
    always_comb begin
        cmd             = decode_cmd(cs_n, ras_n, cas_n, we_n);
        refreshing      = (ref_cnt_q != '0);
        cmd_window_open = (state_q == ST_IDLE) && !refreshing;
        bursting        = (state_q == ST_RD_WAIT) || (state_q == ST_RD) || (state_q == ST_WR);
        rdwr_req        = (cmd == CMD_READ) || (cmd == CMD_WRITE);
        rdwr_accept     = rdwr_req && cmd_window_open && row_active[ba_in];
        lmr_accept      = (cmd == CMD_LOAD_MODE) && cmd_window_open &&
                          mode_valid(addr[2:0], addr[6:4]);
        ref_accept      = (cmd == CMD_REFRESH) && cmd_window_open && (row_active == 4'b0000);
        pre_req         = (cmd == CMD_PRECHARGE);
        stop_burst      = bursting &&
                          ((cmd == CMD_BURST_TERM) ||
                           (pre_req && (addr[A10_BIT] || (ba_in == ba_q))));
        cmd_err_d       = (rdwr_req && !rdwr_accept) ||
                          ((cmd == CMD_LOAD_MODE) && !lmr_accept) ||
                          ((cmd == CMD_REFRESH) && !ref_accept) ||
                          act_reject;
    end

    // Mode register: only a legal LOAD MODE changes burst length, type and CL.
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            burst_len_q  <= BL_CODE_MIN;
            burst_type_q <= 1'b0;
            cas_lat_q    <= 3'(DEFAULT_CL);
        end else if (lmr_accept) begin
            burst_len_q  <= addr[2:0];
            burst_type_q <= addr[3];
            cas_lat_q    <= addr[6:4];
        end
    end

    // Burst start column and bank are captured when a READ/WRITE is accepted.
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            ca_q <= '0;
            ba_q <= '0;
        end else if (rdwr_accept) begin
            ca_q <= addr[COL_WIDTH-1:0];
            ba_q <= ba_in;
        end
    end

    // Refresh timer: holds off commands for TRFC cycles after AUTO REFRESH.
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q <= '0;
        end else if (ref_accept) begin
            ref_cnt_q <= RCW'(TRFC);
        end else if (refreshing) begin
            ref_cnt_q <= ref_cnt_q - 1'b1;
        end
    end

    // Burst FSM with registered beat windows and abort pulse. RD_WAIT covers
    // CL-1 cycles, RD/WR cover BL cycles, GAP is one dead cycle so the array can
    // rewind its beat index. An abort goes straight to GAP, so the stop pulse and
    // the dead cycle coincide.
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            beat_cnt_q     <= '0;
            read_active_q  <= 1'b0;
            write_active_q <= 1'b0;
            burst_stop_q   <= 1'b0;
        end else begin
            burst_stop_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rdwr_accept) begin
                        if (cmd == CMD_READ) begin
                            state_q    <= ST_RD_WAIT;
                            beat_cnt_q <= 4'(cas_lat_q - CL_MIN);
                        end else begin
                            state_q        <= ST_WR;
                            write_active_q <= 1'b1;
                            beat_cnt_q     <= burst_beats(burst_len_q) - 4'd1;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (stop_burst) begin
                        state_q      <= ST_GAP;
                        burst_stop_q <= 1'b1;
                    end else if (beat_cnt_q == 4'd0) begin
                        state_q       <= ST_RD;
                        read_active_q <= 1'b1;
                        beat_cnt_q    <= burst_beats(burst_len_q) - 4'd1;
                    end else begin
                        beat_cnt_q <= beat_cnt_q - 4'd1;
                    end
                end
                ST_RD: begin
                    if (stop_burst) begin
                        state_q       <= ST_GAP;
                        read_active_q <= 1'b0;
                        burst_stop_q  <= 1'b1;
                    end else if (beat_cnt_q == 4'd0) begin
                        state_q       <= ST_GAP;
                        read_active_q <= 1'b0;
                    end else begin
                        beat_cnt_q <= beat_cnt_q - 4'd1;
                    end
                end
                ST_WR: begin
                    if (stop_burst) begin
                        state_q        <= ST_GAP;
                        write_active_q <= 1'b0;
                        burst_stop_q   <= 1'b1;
                    end else if (beat_cnt_q == 4'd0) begin
                        state_q        <= ST_GAP;
                        write_active_q <= 1'b0;
                    end else begin
                        beat_cnt_q <= beat_cnt_q - 4'd1;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q        <= ST_IDLE;
                    read_active_q  <= 1'b0;
                    write_active_q <= 1'b0;
                end
            endcase
        end
    end

    // Reject flag is a one-cycle pulse following the offending command.
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= cmd_err_d;
        end
    end

    assign ca           = ca_q;
    assign ba           = ba_q;
    assign burst_len    = burst_len_q;
    assign burst_type   = burst_type_q;
    assign cas_lat      = cas_lat_q;
    assign read_active  = read_active_q;
    assign write_active = write_active_q;
    assign burst_stop   = burst_stop_q;
    assign cmd_err      = cmd_err_q;
    // Busy is a decode of flops only: burst not retired or refresh timer running.
    assign busy         = (state_q != ST_IDLE) || refreshing;

endmodule
